// File: rtl/dma_engine_rd_buf_pkg.sv
// dma_engine_rd_buf_pkg: shared DMA read-buffer defaults (PCI word width, depth, almost-full margin)
package dma_engine_rd_buf_pkg;
  localparam int PCI_DATA_WIDTH        = 32;
  localparam int DMA_RD_BUF_DEPTH_LOG2 = 4;
  localparam int DMA_RD_BUF_AF_MARGIN  = 2;
endpackage

// File: rtl/dma_rd_buf_regfile.sv
// dma_rd_buf_regfile: word store, one sync write port (we/waddr/wdata), one async read port (raddr/rdata)
module dma_rd_buf_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dma_engine_rd_buf.sv
// dma_engine_rd_buf: FWFT read buffer between DMA alignment stage and PCI master
// Ports: clk, reset_n (async low); push side rd_buf_data/rd_data_rdy/rd_full/rd_almost_full;
// pop side pci_rd_data/rd_buf_empty/pci_pop; rd_buf_cnt words held; flush sync clear.
// DMA_RD_BUF_ERR_CHK_EN adds sticky rd_buf_err for push-while-full / pop-while-empty.
module dma_engine_rd_buf
  import dma_engine_rd_buf_pkg::*;
#(
  parameter int DATA_WIDTH = PCI_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DMA_RD_BUF_DEPTH_LOG2,
  parameter int AF_MARGIN  = DMA_RD_BUF_AF_MARGIN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rd_buf_data,
  input  logic                  rd_data_rdy,
  output logic                  rd_full,
  output logic                  rd_almost_full,
  output logic [DATA_WIDTH-1:0] pci_rd_data,
  output logic                  rd_buf_empty,
  input  logic                  pci_pop,
  output logic [DEPTH_LOG2:0]   rd_buf_cnt,
  input  logic                  flush
`ifdef DMA_RD_BUF_ERR_CHK_EN
  ,
  output logic                  rd_buf_err
`endif
);
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt_nxt;
  logic                  push, pop;
  assign push    = rd_data_rdy & ~rd_full;
  assign pop     = pci_pop & ~rd_buf_empty;
  assign cnt_nxt = flush ? '0 : rd_buf_cnt + CW'(push) - CW'(pop);
  dma_rd_buf_regfile #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(DEPTH_LOG2)) u_regfile (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (rd_buf_data),
    .raddr (rd_ptr),
    .rdata (pci_rd_data)
  );
  // flags come from the next count so they are registered yet exact
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rd_buf_cnt     <= '0;
      rd_buf_empty   <= 1'b1;
      rd_full        <= 1'b0;
      rd_almost_full <= 1'b0;
    end else begin
      wr_ptr         <= flush ? '0 : wr_ptr + DEPTH_LOG2'(push);
      rd_ptr         <= flush ? '0 : rd_ptr + DEPTH_LOG2'(pop);
      rd_buf_cnt     <= cnt_nxt;
      rd_buf_empty   <= cnt_nxt == '0;
      rd_full        <= cnt_nxt == CW'(DEPTH);
      rd_almost_full <= cnt_nxt >= CW'(DEPTH - AF_MARGIN);
    end
`ifdef DMA_RD_BUF_ERR_CHK_EN
  logic viol;
  assign viol = (rd_data_rdy & rd_full) | (pci_pop & rd_buf_empty);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rd_buf_err <= 1'b0;
    else rd_buf_err <= ~flush & (rd_buf_err | viol);
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (reset_n && viol) $display("dma_engine_rd_buf: illegal access push=%0b full=%0b pop=%0b empty=%0b",
                                  rd_data_rdy, rd_full, pci_pop, rd_buf_empty);
`endif
`endif
endmodule

// File: tb/tb_dma_engine_rd_buf.sv
// tb_dma_engine_rd_buf: randomized + directed checks of dma_engine_rd_buf against a queue model
module tb_dma_engine_rd_buf;
  localparam int DEPTH = 16;
  localparam int AFT   = DEPTH - 2;
  logic        clk = 0, reset_n = 0;
  logic [31:0] rd_buf_data = 0;
  logic        rd_data_rdy = 0, pci_pop = 0, flush = 0;
  logic        rd_full, rd_almost_full, rd_buf_empty;
  logic [31:0] pci_rd_data;
  logic [4:0]  rd_buf_cnt;
`ifdef DMA_RD_BUF_ERR_CHK_EN
  logic rd_buf_err;
  logic m_err = 0;
`endif
  int total = 0, bad = 0;
  logic [31:0] q[$];

  dma_engine_rd_buf dut (
    .clk(clk), .reset_n(reset_n), .rd_buf_data(rd_buf_data), .rd_data_rdy(rd_data_rdy),
    .rd_full(rd_full), .rd_almost_full(rd_almost_full), .pci_rd_data(pci_rd_data),
    .rd_buf_empty(rd_buf_empty), .pci_pop(pci_pop), .rd_buf_cnt(rd_buf_cnt), .flush(flush)
`ifdef DMA_RD_BUF_ERR_CHK_EN
    , .rd_buf_err(rd_buf_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state();
    chk("cnt", rd_buf_cnt, q.size());
    chk("empty", rd_buf_empty, q.size() == 0);
    chk("full", rd_full, q.size() == DEPTH);
    chk("afull", rd_almost_full, q.size() >= AFT);
    if (q.size() != 0) chk("data", pci_rd_data, q[0]);
`ifdef DMA_RD_BUF_ERR_CHK_EN
    chk("err", rd_buf_err, m_err);
`endif
  endtask

  // called at posedge+1; applies one cycle of stimulus, then checks at next posedge+1
  task automatic cyc(input logic p, input logic [31:0] d, input logic o, input logic f);
    int n;
    bit do_push, do_pop;
    rd_data_rdy = p; rd_buf_data = d; pci_pop = o; flush = f;
    n = q.size();
    do_push = p && n < DEPTH;
    do_pop  = o && n > 0;
    @(posedge clk);
    #1;
    rd_data_rdy = 0; pci_pop = 0; flush = 0;
`ifdef DMA_RD_BUF_ERR_CHK_EN
    m_err = f ? 1'b0 : (m_err | (p && n == DEPTH) | (o && n == 0));
`endif
    if (f) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    chk_state();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) cyc(1, $urandom, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    chk_state();
    // first push: empty until the edge, data visible right after it
    rd_data_rdy = 1; rd_buf_data = 32'h11223344;
    #2 chk("empty_before_edge", rd_buf_empty, 1);
    @(posedge clk); #1;
    rd_data_rdy = 0;
    q.push_back(32'h11223344);
    chk("first_empty", rd_buf_empty, 0);
    chk("first_data", pci_rd_data, 32'h11223344);
    chk("first_cnt", rd_buf_cnt, 1);
    cyc(0, 0, 0, 1);
    // fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      cyc(1, i, 0, 0);
      if (i == 12) chk("af_at13", rd_almost_full, 0);
      if (i == 13) chk("af_at14", rd_almost_full, 1);
    end
    chk("full16", rd_full, 1);
    cyc(1, 32'hDEAD, 0, 0);
    chk("cnt_after_drop", rd_buf_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", pci_rd_data, i);
      cyc(0, 0, 1, 0);
    end
    chk("drained_empty", rd_buf_empty, 1);
    // steady push+pop at cnt=5 across pointer wrap
    fill(5);
    for (int i = 0; i < 20; i++) cyc(1, $urandom, 1, 0);
    chk("steady_cnt", rd_buf_cnt, 5);
    cyc(0, 0, 0, 1);
    // pop while empty
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("pop_empty_cnt", rd_buf_cnt, 0);
    cyc(0, 0, 0, 1);
    // flush beats simultaneous push and pop
    fill(9);
    cyc(1, 32'hCAFEF00D, 1, 1);
    chk("flush_cnt", rd_buf_cnt, 0);
    cyc(1, 32'h5A5A5A5A, 0, 0);
    chk("post_flush_data", pci_rd_data, 32'h5A5A5A5A);
    cyc(0, 0, 0, 1);
    // async reset between edges
    fill(7);
    reset_n = 0;
    #1;
    q.delete();
`ifdef DMA_RD_BUF_ERR_CHK_EN
    m_err = 0;
`endif
    chk("async_cnt", rd_buf_cnt, 0);
    chk("async_empty", rd_buf_empty, 1);
    chk("async_full", rd_full, 0);
    chk("async_af", rd_almost_full, 0);
    #2 reset_n = 1;
    @(posedge clk); #1;
    chk_state();
    // random traffic, occasionally illegal or flushing
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
